// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - opcode constants, field positions and format helpers shared by decode stages
package ir_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam int OP_LSB     = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    // Unsupported opcodes fall into FMT_R so their immediate reads as zero.
    function automatic imm_fmt_e fmt_of(input logic [6:0] op);
        imm_fmt_e fmt;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            default:                  fmt = FMT_R;
        endcase
        return fmt;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - format-aware immediate builder and illegal-opcode flag
module imm_gen
    import ir_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] instr,
    output logic [D_WIDTH-1:0] imm,
    output logic               illegal
);

    logic [6:0] op;
    logic       sgn;

    assign op      = instr[OP_LSB +: 7];
    assign sgn     = instr[31];
    assign illegal = !is_legal(op);

    always_comb begin
        imm = '0;
        case (fmt_of(op))
            FMT_I: imm = {{(D_WIDTH-12){sgn}}, instr[31:20]};
            FMT_S: imm = {{(D_WIDTH-12){sgn}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(D_WIDTH-13){sgn}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = D_WIDTH'({instr[31:12], 12'b0});
            FMT_J: imm = {{(D_WIDTH-21){sgn}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - DEPTH-entry pre-decoded instruction queue between fetch and register read
module ir_queue
    import ir_pkg::*;
#(
    parameter int D_WIDTH      = 32,
    parameter int N_REGS       = 32,
    parameter int RF_SIZE      = $clog2(N_REGS),
    parameter int DEPTH        = 2,
    parameter int OP_CODE_SIZE = 7,
    parameter int FUNCT_3_SIZE = 3,
    parameter int FUNCT_7_SIZE = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [D_WIDTH-1:0]      isu,
    input  logic [D_WIDTH-1:0]      pc_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [D_WIDTH-1:0]      instr,
    output logic [D_WIDTH-1:0]      pc,
    output logic [RF_SIZE-1:0]      rs1,
    output logic [RF_SIZE-1:0]      rs2,
    output logic [RF_SIZE-1:0]      rd,
    output logic [FUNCT_7_SIZE-1:0] funct7,
    output logic [FUNCT_3_SIZE-1:0] funct3,
    output logic [OP_CODE_SIZE-1:0] op_code,
    output logic [D_WIDTH-1:0]      imm,
    output logic                    illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [D_WIDTH-1:0] instr_mem   [DEPTH];
    logic [D_WIDTH-1:0] pc_mem      [DEPTH];
    logic [D_WIDTH-1:0] imm_mem     [DEPTH];
    logic               illegal_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic               enq;
    logic               deq;
    logic [D_WIDTH-1:0] new_imm;
    logic               new_illegal;

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;

    imm_gen #(
        .D_WIDTH(D_WIDTH)
    ) u_imm_gen (
        .instr  (isu),
        .imm    (new_imm),
        .illegal(new_illegal)
    );

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Payload storage has no reset: only count/pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr]   <= isu;
            pc_mem[wr_ptr]      <= pc_in;
            imm_mem[wr_ptr]     <= new_imm;
            illegal_mem[wr_ptr] <= new_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    logic [D_WIDTH-1:0] head_instr;

    assign head_instr = instr_mem[rd_ptr];

    // Everything downstream sees zeros whenever no head entry exists.
    always_comb begin
        instr   = '0;
        pc      = '0;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        funct7  = '0;
        funct3  = '0;
        op_code = '0;
        imm     = '0;
        illegal = 1'b0;
        if (out_valid) begin
            instr   = head_instr;
            pc      = pc_mem[rd_ptr];
            rs1     = head_instr[RS1_LSB +: RF_SIZE];
            rs2     = head_instr[RS2_LSB +: RF_SIZE];
            rd      = head_instr[RD_LSB +: RF_SIZE];
            funct7  = head_instr[FUNCT7_LSB +: FUNCT_7_SIZE];
            funct3  = head_instr[FUNCT3_LSB +: FUNCT_3_SIZE];
            op_code = head_instr[OP_LSB +: OP_CODE_SIZE];
            imm     = imm_mem[rd_ptr];
            illegal = illegal_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - directed vector and corner-sequence bench for ir_queue
module tb_ir_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] isu;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [6:0]  op_code;
    logic [31:0] imm;
    logic        illegal;

    int checks;
    int failures;

    ir_queue #(
        .D_WIDTH(32),
        .N_REGS (32),
        .DEPTH  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .isu      (isu),
        .pc_in    (pc_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr    (instr),
        .pc       (pc),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .funct7   (funct7),
        .funct3   (funct3),
        .op_code  (op_code),
        .imm      (imm),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] isu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  op;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        isu       = '0;
        pc_in     = '0;

        vecs[0] = '{32'h00510093, 32'h100, 5'd1,  5'd2,  5'd5,  3'd0, 7'h00, 7'h13, 32'h00000005, 1'b0};
        vecs[1] = '{32'hFE512E23, 32'h104, 5'd28, 5'd2,  5'd5,  3'd2, 7'h7F, 7'h23, 32'hFFFFFFFC, 1'b0};
        vecs[2] = '{32'h123451B7, 32'h108, 5'd3,  5'd8,  5'd3,  3'd5, 7'h09, 7'h37, 32'h12345000, 1'b0};
        vecs[3] = '{32'h0000007F, 32'h10C, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 7'h7F, 32'h00000000, 1'b1};
        vecs[4] = '{32'hFE208CE3, 32'h110, 5'd25, 5'd1,  5'd2,  3'd0, 7'h7F, 7'h63, 32'hFFFFFFF8, 1'b0};
        vecs[5] = '{32'h001010EF, 32'h114, 5'd1,  5'd0,  5'd1,  3'd1, 7'h00, 7'h6F, 32'h00001800, 1'b0};
        vecs[6] = '{32'hFFFFF297, 32'h118, 5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 7'h17, 32'hFFFFF000, 1'b0};
        vecs[7] = '{32'h80002083, 32'h11C, 5'd1,  5'd0,  5'd0,  3'd2, 7'h40, 7'h03, 32'hFFFFF800, 1'b0};
        vecs[8] = '{32'h002081B3, 32'h120, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 7'h33, 32'h00000000, 1'b0};
        vecs[9] = '{32'hFFC08067, 32'h124, 5'd0,  5'd1,  5'd28, 3'd0, 7'h7F, 7'h67, 32'hFFFFFFFC, 1'b0};

        tick;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_imm", imm, 32'd0);
        rst = 1'b0;
        tick;

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            isu      = vecs[i].isu;
            pc_in    = vecs[i].pc;
            tick;
            in_valid = 1'b0;
            isu      = 32'hDEADBEEF;
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d_instr", i), instr, vecs[i].isu);
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_rd", i), {27'b0, rd}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d_rs1", i), {27'b0, rs1}, {27'b0, vecs[i].rs1});
            check($sformatf("v%0d_rs2", i), {27'b0, rs2}, {27'b0, vecs[i].rs2});
            check($sformatf("v%0d_funct3", i), {29'b0, funct3}, {29'b0, vecs[i].f3});
            check($sformatf("v%0d_funct7", i), {25'b0, funct7}, {25'b0, vecs[i].f7});
            check($sformatf("v%0d_op", i), {25'b0, op_code}, {25'b0, vecs[i].op});
            check($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            check($sformatf("v%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
            tick;
            check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'd0);
        end

        // Fill to full with consumer stalled; C must be held back.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        isu = 32'h00100093; pc_in = 32'h200;
        tick;
        isu = 32'h00200113; pc_in = 32'h204;
        tick;
        isu = 32'h00300193; pc_in = 32'h208;
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        tick;
        check("full_hold_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_hold_head", instr, 32'h00100093);
        check("full_hold_pc", pc, 32'h200);
        out_ready = 1'b1;
        #1;
        check("full_ready_indep", {31'b0, in_ready}, 32'd0);
        tick;
        check("order_b", instr, 32'h00200113);
        check("order_b_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        check("order_c", instr, 32'h00300193);
        check("order_c_pc", pc, 32'h208);
        tick;
        check("order_empty", {31'b0, out_valid}, 32'd0);

        // Flush with two queued and a same-cycle enqueue attempt.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        isu = 32'h00510093; pc_in = 32'h300;
        tick;
        isu = 32'hFE512E23; pc_in = 32'h304;
        tick;
        flush = 1'b1;
        isu = 32'h123451B7; pc_in = 32'h308;
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_instr", instr, 32'd0);
        check("flush_pc", pc, 32'd0);
        check("flush_imm", imm, 32'd0);
        tick;
        check("flush_not_stored", {31'b0, out_valid}, 32'd0);

        // Async reset mid-occupancy clears without waiting for an edge.
        in_valid = 1'b1;
        isu = 32'h002081B3; pc_in = 32'h400;
        tick;
        in_valid = 1'b0;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_instr", instr, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register and decode queue between instruction fetch and the register-file/ALU stage. It replaces the single-entry, enable-loaded instruction register with a DEPTH-entry FIFO and a valid/ready handshake on both sides. Each entry carries a PC tag. The block also adds flush, format-aware immediate generation and illegal-opcode flagging. Fields are split and the immediate is built at enqueue time, so the head entry presents fully decoded, registered outputs.

## Interface
- D_WIDTH, 32: instruction and PC width. Decode field positions assume 32.
- N_REGS, 32: architectural register count.
- RF_SIZE, $clog2(N_REGS): register index width.
- DEPTH, 2: queue entries. Any value ≥ 1; need not be a power of two.
- OP_CODE_SIZE, 7 / FUNCT_3_SIZE, 3 / FUNCT_7_SIZE, 7: field widths.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- isu  in  D_WIDTH  instruction word.
- pc_in  in  D_WIDTH  PC of isu.
- out_valid  out  1  head entry present; equals (count != 0).
- out_ready  in  1  consumer takes the head.
- instr, pc  out  D_WIDTH  head instruction and its PC.
- rs1, rs2, rd  out  RF_SIZE  head register fields.
- funct7 / funct3 / op_code  out  7/3/7  head fields.
- imm  out  D_WIDTH  sign-extended immediate for the head.
- illegal  out  1  head op_code is not in the supported set.

## Operation
- Enqueue when in_valid && in_ready && !flush. Dequeue when out_valid && out_ready && !flush.
- Field split: funct7=[31:25], rs2=[24:20], rs1=[19:15], funct3=[14:12], rd=[11:7], op_code=[6:0].
- Immediate selected by op_code:
  - I-type (0x03, 0x13, 0x67): {sext,[31:20]}
  - S-type (0x23): {sext,[31:25],[11:7]}
  - B-type (0x63): {sext,[31],[7],[30:25],[11:8],0}
  - U-type (0x37, 0x17): {[31:12],12'b0}
  - J-type (0x6F): {sext,[31],[19:12],[20],[30:21],0}
  - R-type (0x33) and all others: 0
- illegal=1 for any op_code outside {03,13,17,23,33,37,63,67,6F}. Illegal instructions are still queued and presented.
- Storage holds pre-decoded entries. Read/write pointers wrap at DEPTH-1 → 0. count is 0..DEPTH.
- Every output other than in_ready/out_valid is forced to 0 while out_valid=0.

## Timing
- Reset (async): count=0 and both pointers=0, so in_ready=1, out_valid=0 and all data outputs are 0.
- Latency: an instruction enqueued at edge N is visible at the outputs (out_valid=1) after edge N. There is no combinational isu→output path.
- Full (count=DEPTH): in_ready=0. Simultaneous enqueue on a dequeue cycle is not accepted while full; in_ready has no combinational dependence on out_ready.
- Empty: out_valid=0. Same-cycle enqueue+dequeue is impossible because out_valid=0.
- Simultaneous enqueue+dequeue when 0 < count < DEPTH: count unchanged, both pointers advance.
- flush: at the next edge count=0 and pointers=0. It overrides any same-cycle enqueue and dequeue.
- rst asserted mid-transfer: state clears immediately and the in-flight word is lost.
- Outputs stay stable while out_valid && !out_ready.

## Structure
- Shared package ir_pkg holds the opcode localparams (OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL) and the field bit-position constants. The future decoder and ALU control import the same package.
- One combinational sub-module, imm_gen (instr in → imm, illegal out), is instantiated on the enqueue path.
- The queue itself (storage arrays, pointers, count) lives in ir_queue.

## Test plan
- Reset then push 0x00510093 (addi x1,x2,5) at pc 0x100, out_ready=1 → next cycle out_valid=1, rd=1, rs1=2, funct3=0, op_code=0x13, imm=0x00000005, pc=0x100, illegal=0; one cycle later out_valid=0.
- Push 0xFE512E23 (sw x5,-4(x2)) → rs1=2, rs2=5, funct3=2, imm=0xFFFFFFFC.
- Push 0x123451B7 (lui x3,0x12345) → rd=3, imm=0x12345000.
- Push 0x0000007F → illegal=1, imm=0.
- DEPTH=2, out_ready=0: push A, B, C → in_ready=0 after two accepts and C is held by the source. Raise out_ready → A then B emerge in order; C enters after the first dequeue and emerges third.
- With 2 entries queued, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, outputs 0, and the flushed-cycle word is not stored.
